cnn_mac_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit for the conv layers. It generalises the combinational signed multiplier primitive: configurable operand widths, multiply pipeline depth and clock enable. It adds a multi-beat accumulation window, fixed-point round/shift, output saturation and a valid handshake. The block sits between the line-buffer operand fetch and the output-feature writeback, and produces one result per kernel window.

---
 rtl/cnn_mac_pipe_if.sv | 28 ++
 rtl/cnn_mac_pipe.sv | 152 +++++++++++++++
 tb/tb_cnn_mac_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_mac_pipe_if.sv
// Operand beat stream into the conv-layer MAC and the per-window result back out.
// The producer uses master; the MAC itself uses slave.
interface cnn_mac_pipe_if #(
  parameter int A_W   = 9,
  parameter int B_W   = 14,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_first;
  logic                    in_last;
  logic signed [A_W-1:0]   din0;
  logic signed [B_W-1:0]   din1;
  logic                    out_valid;
  logic signed [OUT_W-1:0] dout;
  logic signed [ACC_W-1:0] acc_dout;
  logic                    sat_flag;

  modport master (
    output in_valid, in_first, in_last, din0, din1,
    input  out_valid, dout, acc_dout, sat_flag
  );

  modport slave (
    input  in_valid, in_first, in_last, din0, din1,
    output out_valid, dout, acc_dout, sat_flag
  );
endinterface

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC: input regs, MUL_STAGES product regs, windowed accumulator,
// then round-half-up shift and saturation into a one-cycle result pulse.
module cnn_mac_pipe #(
  parameter int A_W        = 9,
  parameter int B_W        = 14,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int MUL_STAGES = 2
) (
  input logic           ap_clk,
  input logic           ap_rst,
  input logic           ce,
  cnn_mac_pipe_if.slave bus
);
  localparam int P_W = A_W + B_W;

  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  in_v_q, in_f_q, in_l_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      in_v_q <= 1'b0;
      in_f_q <= 1'b0;
      in_l_q <= 1'b0;
    end else if (ce) begin
      a_q    <= bus.din0;
      b_q    <= bus.din1;
      in_v_q <= bus.in_valid;
      in_f_q <= bus.in_valid & bus.in_first;
      in_l_q <= bus.in_valid & bus.in_last;
    end
  end

  logic signed [P_W-1:0] prod_d;
  assign prod_d = a_q * b_q;

  // Product register chain; window tags ride alongside each product.
  for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_mul
    logic signed [P_W-1:0] p_d, p_q;
    logic                  v_d, f_d, l_d;
    logic                  v_q, f_q, l_q;

    if (gi == 0) begin : g_src
      assign p_d = prod_d;
      assign v_d = in_v_q;
      assign f_d = in_f_q;
      assign l_d = in_l_q;
    end else begin : g_src
      assign p_d = g_mul[gi-1].p_q;
      assign v_d = g_mul[gi-1].v_q;
      assign f_d = g_mul[gi-1].f_q;
      assign l_d = g_mul[gi-1].l_q;
    end

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        p_q <= '0;
        v_q <= 1'b0;
        f_q <= 1'b0;
        l_q <= 1'b0;
      end else if (ce) begin
        p_q <= p_d;
        v_q <= v_d;
        f_q <= f_d;
        l_q <= l_d;
      end
    end
  end

  logic signed [P_W-1:0]   mul_p;
  logic                    mul_v, mul_f, mul_l;
  logic signed [ACC_W-1:0] prod_ext, acc_d, acc_q;
  logic                    acc_l_q;

  assign mul_p    = g_mul[MUL_STAGES-1].p_q;
  assign mul_v    = g_mul[MUL_STAGES-1].v_q;
  assign mul_f    = g_mul[MUL_STAGES-1].f_q;
  assign mul_l    = g_mul[MUL_STAGES-1].l_q;
  assign prod_ext = ACC_W'(mul_p);
  assign acc_d    = mul_f ? prod_ext : acc_q + prod_ext;

  // Accumulator wraps on overflow; only the output stage saturates.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q   <= '0;
      acc_l_q <= 1'b0;
    end else if (ce) begin
      if (mul_v) begin
        acc_q <= acc_d;
      end
      acc_l_q <= mul_v & mul_l;
    end
  end

  logic signed [ACC_W:0] acc_x, r_d;
  assign acc_x = (ACC_W + 1)'(acc_q);

  if (SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
    assign r_d = (acc_x + HALF) >>> SHIFT;
  end else begin : g_noround
    assign r_d = acc_x;
  end

  logic [OUT_W-1:0] dout_d;
  logic             sat_d;

  always_comb begin
    dout_d = r_d[OUT_W-1:0];
    sat_d  = 1'b0;
    if (r_d > OUT_MAX) begin
      dout_d = OUT_MAX[OUT_W-1:0];
      sat_d  = 1'b1;
    end else if (r_d < OUT_MIN) begin
      dout_d = OUT_MIN[OUT_W-1:0];
      sat_d  = 1'b1;
    end
  end

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] dout_q;
  logic signed [ACC_W-1:0] acc_dout_q;
  logic                    sat_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      acc_dout_q  <= '0;
      sat_q       <= 1'b0;
    end else if (ce) begin
      out_valid_q <= acc_l_q;
      if (acc_l_q) begin
        dout_q     <= dout_d;
        acc_dout_q <= acc_q;
        sat_q      <= sat_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.acc_dout  = acc_dout_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: directed windows from the test plan plus randomized windows
// with bubbles and clock-enable gaps, checked against a window-level arithmetic model.
module tb_cnn_mac_pipe;
  localparam int A_W = 9, B_W = 14, ACC_W = 32, OUT_W = 16, SHIFT = 8, MUL_STAGES = 2;
  localparam int LAT = MUL_STAGES + 2;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ce     = 1'b1;

  cnn_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  cnn_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .MUL_STAGES(MUL_STAGES)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint acc;
    longint dout;
    bit     sat;
    longint edge_no;
  } res_t;

  res_t   obs_q[$];
  res_t   exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint edge_cnt = 0;
  longint model_acc = 0;
  bit     mon_ce, mon_rst;
  longint mon_p;

  function automatic longint wrap_acc(input longint x);
    longint m = longint'(1) << ACC_W;
    longint y = x % m;
    if (y < 0) y += m;
    if (y >= m / 2) y -= m;
    return y;
  endfunction

  // Window result straight from the arithmetic rules: round half up, shift, clamp.
  function automatic res_t ref_result(input longint acc);
    res_t   r;
    longint num, d, q;
    longint omax = (longint'(1) << (OUT_W - 1)) - 1;
    longint omin = -(longint'(1) << (OUT_W - 1));
    q = acc;
    if (SHIFT > 0) begin
      d   = longint'(1) << SHIFT;
      num = acc + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
    end
    r.acc = acc;
    r.sat = 1'b0;
    r.dout = q;
    if (q > omax) begin r.dout = omax; r.sat = 1'b1; end
    if (q < omin) begin r.dout = omin; r.sat = 1'b1; end
    r.edge_no = 0;
    return r;
  endfunction

  // Model update and result capture at every clock edge.
  initial forever begin
    @(posedge ap_clk);
    edge_cnt++;
    mon_ce  = ce;
    mon_rst = ap_rst;
    if (mon_rst) begin
      model_acc = 0;
      exp_q.delete();
    end else if (mon_ce && bus.in_valid === 1'b1) begin
      mon_p     = longint'(bus.din0) * longint'(bus.din1);
      model_acc = wrap_acc((bus.in_first ? 0 : model_acc) + mon_p);
      if (bus.in_last) exp_q.push_back(ref_result(model_acc));
    end
    #1;
    if (!mon_rst && mon_ce && bus.out_valid === 1'b1)
      obs_q.push_back('{acc: longint'(bus.acc_dout), dout: longint'(bus.dout),
                        sat: bus.sat_flag, edge_no: edge_cnt});
  end

  task automatic set_in(input bit v, input bit f, input bit l, input int a, input int b);
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_last  = l;
    bus.din0     = A_W'(a);
    bus.din1     = B_W'(b);
  endtask

  task automatic beat(input bit v, input bit f, input bit l, input int a, input int b);
    set_in(v, f, l, a, b);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 511)), int'($urandom_range(0, 16383)));
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce = 1'($urandom_range(0, 1));
      beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 511)), int'($urandom_range(0, 16383)));
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_vec++;
      if (bus.dout !== '0) begin n_err++; $display("FAIL reset_dout: got %0d want 0", bus.dout); end
      n_vec++;
      if (bus.acc_dout !== '0) begin n_err++; $display("FAIL reset_acc_dout: got %0d want 0", bus.acc_dout); end
      n_vec++;
      if (bus.sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat_flag: got %b want 0", bus.sat_flag); end
    end
    ap_rst = 1'b0;
    ce     = 1'b1;
  endtask

  task automatic test_idle();
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      idle(1);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid[%0d]: got %b want 0", i, bus.out_valid); end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL idle_results: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_single_term();
    res_t   o;
    longint n_edge;
    obs_q.delete();
    beat(1'b1, 1'b1, 1'b1, 3, 512);
    n_edge = edge_cnt;
    idle(8);
    n_vec++;
    if (obs_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_vec++;
      if (o.edge_no != n_edge + LAT) begin n_err++; $display("FAIL single_latency: got edge %0d want edge %0d", o.edge_no, n_edge + LAT); end
      n_vec++;
      if (o.acc != 1536) begin n_err++; $display("FAIL single_acc: got %0d want 1536", o.acc); end
      n_vec++;
      if (o.dout != 6) begin n_err++; $display("FAIL single_dout: got %0d want 6", o.dout); end
      n_vec++;
      if (o.sat !== 1'b0) begin n_err++; $display("FAIL single_sat: got %b want 0", o.sat); end
    end
  endtask

  task automatic test_neg_round();
    res_t   o;
    longint ea[2] = '{-2096896, -128};
    longint ed[2] = '{-8191, 0};
    obs_q.delete();
    beat(1'b1, 1'b1, 1'b1, -256, 8191);
    beat(1'b1, 1'b1, 1'b1, -1, 128);
    idle(8);
    n_vec++;
    if (obs_q.size() != 2) begin n_err++; $display("FAIL neg_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_vec++;
      if (o.acc != ea[i] || o.dout != ed[i] || o.sat !== 1'b0) begin
        n_err++;
        $display("FAIL neg_result[%0d]: got acc=%0d dout=%0d sat=%b want acc=%0d dout=%0d sat=0",
                 i, o.acc, o.dout, o.sat, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_saturation();
    res_t   o;
    int     av[2] = '{255, -256};
    longint ea[2] = '{33419280, -33550336};
    longint ed[2] = '{32767, -32768};
    obs_q.delete();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++) beat(1'b1, i == 0, i == 15, av[w], 8191);
    idle(8);
    n_vec++;
    if (obs_q.size() != 2) begin n_err++; $display("FAIL sat_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_vec++;
      if (o.acc != ea[i] || o.dout != ed[i] || o.sat !== 1'b1) begin
        n_err++;
        $display("FAIL sat_result[%0d]: got acc=%0d dout=%0d sat=%b want acc=%0d dout=%0d sat=1",
                 i, o.acc, o.dout, o.sat, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_ce_bubbles();
    res_t   o;
    int     k = 0;
    bit     taken, prev_ov;
    longint ea[2] = '{45, 200};
    longint ed[2] = '{0, 1};
    obs_q.delete();
    // Nine-beat window with bubbles after odd beats, then a one-beat window right behind it.
    for (int i = 0; i < 12 + 20; i++) begin
      taken = 1'b0;
      while (!taken) begin
        ce = ((k / 2) % 2) == 0;
        k++;
        if (i < 9 || (i == 9)) begin
          set_in(1'b1, i == 0 || i == 9, i == 8 || i == 9, (i == 9) ? 2 : 1, (i == 9) ? 100 : i + 1);
        end else begin
          set_in(1'b0, 1'b1, 1'b1, 7, 7);
        end
        prev_ov = bus.out_valid;
        @(posedge ap_clk);
        #1;
        if (!ce) begin
          n_vec++;
          if (bus.out_valid !== prev_ov) begin n_err++; $display("FAIL ce_hold_out_valid: got %b want %b", bus.out_valid, prev_ov); end
        end
        taken = ce;
      end
      if (i < 9 && (i % 2) == 1) begin
        taken = 1'b0;
        while (!taken) begin
          ce = ((k / 2) % 2) == 0;
          k++;
          set_in(1'b0, 1'b1, 1'b0, 99, 99);
          @(posedge ap_clk);
          #1;
          taken = ce;
        end
      end
    end
    ce = 1'b1;
    idle(4);
    n_vec++;
    if (obs_q.size() != 2) begin n_err++; $display("FAIL ce_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_vec++;
      if (o.acc != ea[i] || o.dout != ed[i] || o.sat !== 1'b0) begin
        n_err++;
        $display("FAIL ce_result[%0d]: got acc=%0d dout=%0d sat=%b want acc=%0d dout=%0d sat=0",
                 i, o.acc, o.dout, o.sat, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    res_t o;
    obs_q.delete();
    beat(1'b1, 1'b1, 1'b0, 100, 1000);
    beat(1'b1, 1'b0, 1'b0, 100, 1000);
    ap_rst = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 100, 1000);
    beat(1'b1, 1'b0, 1'b1, 100, 1000);
    ap_rst = 1'b0;
    idle(10);
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL midrst_no_result: got %0d want 0", obs_q.size()); end
    obs_q.delete();
    // First beat carries no first flag, so it lands on whatever the accumulator holds.
    beat(1'b1, 1'b0, 1'b1, 10, 10);
    beat(1'b1, 1'b1, 1'b1, 10, 10);
    idle(8);
    n_vec++;
    if (obs_q.size() != 2) begin n_err++; $display("FAIL midrst_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_vec++;
      if (o.acc != 100 || o.dout != 0 || o.sat !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_result[%0d]: got acc=%0d dout=%0d sat=%b want acc=100 dout=0 sat=0",
                 i, o.acc, o.dout, o.sat);
      end
    end
  endtask

  task automatic rand_beat(input bit v, input bit f, input bit l, input int a, input int b);
    bit taken = 1'b0;
    while (!taken) begin
      ce    = $urandom_range(0, 4) != 0;
      taken = ce;
      beat(v, f, l, a, b);
    end
    ce = 1'b1;
  endtask

  task automatic test_random();
    res_t o, e;
    int   len, idx;
    idle(8);
    obs_q.delete();
    exp_q.delete();
    for (int w = 0; w < 40; w++) begin
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        while ($urandom_range(0, 3) == 0)
          rand_beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5, 5);
        rand_beat(1'b1, j == 0, j == len - 1,
                  int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 16383)) - 8192);
      end
    end
    idle(10);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (o.acc != e.acc || o.dout != e.dout || o.sat !== e.sat) begin
        n_err++;
        $display("FAIL rand_result[%0d]: got acc=%0d dout=%0d sat=%b want acc=%0d dout=%0d sat=%b",
                 idx, o.acc, o.dout, o.sat, e.acc, e.dout, e.sat);
      end
      idx++;
    end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 0, 0);
    test_reset();
    test_idle();
    test_single_term();
    test_neg_round();
    test_saturation();
    test_ce_bubbles();
    test_reset_mid_window();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
